// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed LATENCY, valid/ready response.
// Optional byte strobes on stores are enabled with `define DMEM_BYTE_STROBE_EN.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_be_i,
`endif
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          write_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          accept;
  logic          access;
  logic          err;
  logic [AW-1:0] idx;
  logic [31:0]   mem [DEPTH];

  assign accept      = (state == IDLE) && req_valid_i;
  assign access      = (state == WAIT) && (cnt == 4'd0);
  // Full 30-bit word index compare, so addresses never alias modulo DEPTH.
  assign err         = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
  assign idx         = addr_q[AW+1:2];
  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment first guarantees no latch is inferred on any path.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_valid_i) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt         <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp_rdata_o <= 32'd0;
      rsp_err_o   <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        cnt     <= 4'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        rsp_err_o   <= err;
        rsp_rdata_o <= (!err && !write_q) ? mem[idx] : 32'd0;
      end else if ((state == RESP) && rsp_ready_i) begin
        rsp_err_o <= 1'b0;
      end
    end
  end

`ifdef DMEM_BYTE_STROBE_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      be_q <= 4'h0;
    else if (accept) be_q <= req_be_i;
  end
`else
  assign be_q = 4'hF;
`endif

  // NOTE: the array is deliberately not reset; contents survive rst_i, and a store
  // still in WAIT at reset never reaches this commit.
  always_ff @(posedge clk_i) begin
    if (access && write_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: transaction-level reference model plus directed and random traffic.
module tb_dmem_responder;

  localparam int DEPTH   = 128;
  localparam int LATENCY = 2;

  logic        clk;
  logic        rst_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be_i    (req_be),
`endif
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_busy;
  bit          m_valid;
  int          m_age;
  bit          m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  bit          m_err;

  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_age   = 0;
      m_err   = 1'b0;
    end else if (m_valid) begin
      if (rsp_ready) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
        m_err   = 1'b0;
      end
    end else if (m_busy) begin
      m_age++;
      if (m_age == LATENCY) begin
        logic [31:0] word;
        word    = m_addr >> 2;
        m_err   = (m_addr % 4 != 0) || (word >= DEPTH);
        m_rdata = 32'd0;
        if (!m_err) begin
          if (m_write) begin
            for (int b = 0; b < 4; b++)
              if (m_be[b]) m_mem[int'(word)][8*b +: 8] = m_wdata[8*b +: 8];
          end else begin
            m_rdata = m_mem[int'(word)];
          end
        end
        m_valid = 1'b1;
      end
    end else if (req_valid) begin
      m_busy  = 1'b1;
      m_age   = 0;
      m_write = req_write;
      m_addr  = req_addr;
      m_wdata = req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
      m_be    = req_be;
`else
      m_be    = 4'hF;
`endif
    end
  end

  // Per-cycle comparison against the model, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_i) begin
        check("req_ready", 32'(req_ready), 32'(!m_busy));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid) begin
          check("rsp_err", 32'(rsp_err), 32'(m_err));
          check("rsp_rdata", rsp_rdata, m_rdata);
        end else begin
          check("rsp_err_idle", 32'(rsp_err), 32'd0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input int hold, output logic [31:0] rd, output bit er);
    int n;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    n = 1;
    while (!rsp_valid && n < 40) begin
      rsp_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b0;
    rd = 32'd0;
    er = 1'b0;
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'd1);
      return;
    end
    check("latency", 32'(n), 32'(LATENCY + 1));
    repeat (hold) @(negedge clk);
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  bit          er;
  logic [31:0] prior;

  initial begin
    rst_i     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'hF;
    rsp_ready = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);

    // Preload every word so later loads have defined contents.
    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), $urandom, 4'hF, 0, rd, er);

    // Store then load.
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er);
    check("st10_rdata", rd, 32'd0);
    check("st10_err", 32'(er), 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    check("ld10_rdata", rd, 32'hDEADBEEF);
    check("ld10_err", 32'(er), 32'd0);

    // Misaligned store leaves the array alone.
    xact(1'b1, 32'h13, 32'h1, 4'hF, 0, rd, er);
    check("st13_err", 32'(er), 32'd1);
    check("st13_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er);
    check("ld10_again", rd, 32'hDEADBEEF);

    // Range boundary.
    xact(1'b0, 32'h200, 32'h0, 4'hF, 0, rd, er);
    check("ld200_err", 32'(er), 32'd1);
    check("ld200_rdata", rd, 32'd0);
    xact(1'b1, 32'h1FC, 32'hCAFEF00D, 4'hF, 0, rd, er);
    xact(1'b0, 32'h1FC, 32'h0, 4'hF, 0, rd, er);
    check("ld1fc_err", 32'(er), 32'd0);
    check("ld1fc_rdata", rd, 32'hCAFEF00D);
    xact(1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, rd, er);
    check("ld_nowrap_err", 32'(er), 32'd1);

    // Back-pressure: per-cycle compare checks valid/ready/rdata throughout.
    xact(1'b0, 32'h10, 32'h0, 4'hF, 5, rd, er);
    check("bp_rdata", rd, 32'hDEADBEEF);
    check("bp_ready_after", 32'(req_ready), 32'd1);

    // Reset while the store sits in WAIT.
    xact(1'b0, 32'h20, 32'h0, 4'hF, 0, prior, er);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h55AA55AA;
    req_be    = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    rst_i     = 1'b0;
    #1;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_rdata", rsp_rdata, 32'd0);
    check("midrst_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    xact(1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er);
    check("midrst_ld20_prior", rd, prior);
    check("midrst_ld20_not_new", 32'(rd == 32'h55AA55AA), 32'd0);

`ifdef DMEM_BYTE_STROBE_EN
    xact(1'b1, 32'h30, 32'h11223344, 4'hF, 0, rd, er);
    xact(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 0, rd, er);
    xact(1'b0, 32'h30, 32'h0, 4'b0000, 0, rd, er);
    check("be_merge", rd, 32'h11BB33DD);
    xact(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, 0, rd, er);
    check("be_zero_err", 32'(er), 32'd0);
    xact(1'b0, 32'h30, 32'h0, 4'hF, 0, rd, er);
    check("be_zero_nochange", rd, 32'h11BB33DD);
`endif

    // Random traffic: mostly legal, with misaligned and out-of-range mixed in.
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else if (sel == 8) a = 32'((DEPTH + $urandom_range(0, 15)) * 4);
      else               a = $urandom;
      xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd, er);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory-side end of the CPU load/store interface.
- Accepts one word request at a time on a valid/ready request channel, waits a programmable latency, then commits the write or samples the read.
- Returns a response on a valid/ready response channel.
- Sits behind the CPU core's load/store port; replaces the zero-latency data memory once the core moves to stall-capable memory access.

Parameters:
- DEPTH, 128: number of 32-bit words in the array; power of two, >= 4.
- LATENCY, 2: cycles from request acceptance to the response becoming valid; legal range 1..15.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  responder can accept a request.
- req_write_i  input  1  1 = store, 0 = load.
- req_addr_i  input  32  byte address.
- req_wdata_i  input  32  store data.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  CPU accepts the response.
- rsp_rdata_o  output  32  load data; 0 for stores and errors.
- rsp_err_o  output  1  misaligned or out-of-range access.

Behaviour:
- Reset (rst_i low, asynchronous):
  - FSM goes to IDLE.
  - req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - Latency counter = 0.
  - Memory contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i && req_ready_o: latch write, addr and wdata into request registers; load counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready_o=0.
  - If counter != 0, decrement.
  - If counter == 0, perform the access and go to RESP.
  - With LATENCY=1, WAIT lasts exactly one cycle.
  - Net timing: the response is valid exactly LATENCY cycles after the accept edge.
- Access, evaluated once at the WAIT->RESP edge:
  - err = (addr[1:0] != 0) || (addr[31:2] >= DEPTH).
  - Store with !err: mem[addr[31:2]] <= wdata; rsp_rdata_o <= 0.
  - Load with !err: rsp_rdata_o <= mem[addr[31:2]].
  - err: no array write; rsp_rdata_o <= 0; rsp_err_o <= 1.
  - Word index comparison is full 30-bit; addresses never wrap modulo DEPTH.
- RESP:
  - rsp_valid_o=1; rdata and err held stable.
  - On rsp_ready_i: rsp_valid_o<=0, rsp_err_o<=0, go to IDLE.
  - req_ready_o stays 0 in RESP, including the handshake cycle. The next request is accepted no earlier than the cycle after the response handshake.
- Request inputs are sampled only at the accept edge; changes while in WAIT or RESP are ignored.
- Back-pressure: rsp_ready_i held low keeps the FSM in RESP indefinitely; no further requests are accepted.
- Reset mid-operation:
  - Reset during WAIT drops the pending store; the array is unchanged.
  - Reset during RESP discards the response.
- Read-after-write: a load that follows a store to the same word observes the stored data. The store commits before its own response.

Optional Feature:
- Macro: DMEM_BYTE_STROBE_EN.
- Defined:
  - Adds port req_be_i, input, 4 bits, latched with the request.
  - A store writes only the bytes whose strobe bit is set; bit n maps to mem bits [8n+7:8n].
  - Store with req_be_i=0 commits nothing but still returns a normal response.
  - Loads ignore req_be_i and return the full word.
- Undefined:
  - No req_be_i port.
  - Every store writes all 4 bytes.

Test Plan:
- Store then load, LATENCY=2:
  - Store addr 0x10, data 0xDEADBEEF -> rsp_valid_o high 2 cycles after accept, rdata 0, err 0.
  - Then load 0x10 -> rdata 0xDEADBEEF, err 0.
- Misaligned store:
  - Store to 0x13 data 0x1 -> err 1.
  - Subsequent load 0x10 still returns 0xDEADBEEF.
- Out of range, DEPTH=128:
  - Load 0x200 -> err 1, rdata 0.
  - Load 0x1FC -> err 0.
- Back-pressure:
  - Hold rsp_ready_i=0 for 5 cycles -> rsp_valid_o stays 1, rdata stable, req_ready_o 0 throughout.
  - Assert rsp_ready_i -> req_ready_o 1 on the next cycle.
- Reset mid-WAIT:
  - Store 0x20 data 0x55AA55AA; pull rst_i low one cycle after accept -> outputs at reset values immediately.
  - Load 0x20 after reset returns the prior content, not 0x55AA55AA.
- With DMEM_BYTE_STROBE_EN:
  - mem[0x30]=0x11223344; store 0x30, data 0xAABBCCDD, be=4'b0101 -> load 0x30 returns 0x11BB33DD.
